// File: rtl/edsac_acc_pkg.sv
// Shared encodings for the bit-serial accumulator controller: op codes,
// controller states and the default short-word width.
package edsac_acc_pkg;

  localparam int DEFAULT_WORD_BITS = 18;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'b00,
    ST_IDLE   = 2'b01,
    ST_ADD    = 2'b10,
    ST_FINISH = 2'b11
  } state_e;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load serialiser: presents the word LSB first on bit_o and fills
// with zeros behind it, so the stream reads 0 once the word is exhausted.
module piso_shift
  import edsac_acc_pkg::*;
#(
  parameter int WORD_BITS = DEFAULT_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [WORD_BITS-1:0] data_i,
  output logic                 bit_o
);

  logic [WORD_BITS-1:0] sreg_q, sreg_d;

  // Next-state: load has priority over shifting.
  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = {1'b0, sreg_q[WORD_BITS-1:1]};
    end else begin
      sreg_d = sreg_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign bit_o = sreg_q[0];

endmodule

// File: rtl/serial_accumulator.sv
// Bit-serial accumulator controller: streams accumulator and addend into an
// external serial adder, collects the delayed sum and flushes adder carries.
module serial_accumulator
  import edsac_acc_pkg::*;
#(
  parameter int WORD_BITS   = DEFAULT_WORD_BITS,
  parameter int ADD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WORD_BITS-1:0] load_word,
  input  logic [WORD_BITS-1:0] add_word,
  output logic                 adder_a,
  output logic                 adder_b,
  input  logic                 adder_sum,
  output logic [WORD_BITS-1:0] acc_word,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(WORD_BITS + ADD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(ADD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS + ADD_LATENCY);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] acc_q, acc_d;
  logic [WORD_BITS-1:0] res_q, res_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_s;
  logic                 shift_s;

  piso_shift #(.WORD_BITS(WORD_BITS)) u_piso_acc (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_s),
    .shift_i(shift_s),
    .data_i (acc_q),
    .bit_o  (adder_a)
  );

  piso_shift #(.WORD_BITS(WORD_BITS)) u_piso_add (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_s),
    .shift_i(shift_s),
    .data_i (add_word),
    .bit_o  (adder_b)
  );

  // Next-state and output logic; FINISH accepts a new op just like IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (cnt_q == CNT_LAT) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          case (op)
            OP_ADD: begin
              state_d = ST_ADD;
              busy_d  = 1'b1;
              cnt_d   = '0;
              load_s  = 1'b1;
            end
            OP_CLEAR: begin
              acc_d  = '0;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_LOAD: begin
              acc_d  = load_word;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      ST_ADD: begin
        shift_s = 1'b1;
        cnt_d   = cnt_q + CNT_ONE;
        // Sum bits arrive ADD_LATENCY digits behind the inputs; the final one is the carry.
        if (cnt_q == CNT_LAST) begin
          acc_d   = res_q;
          ovf_d   = adder_sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_FINISH;
        end else if (cnt_q >= CNT_LAT) begin
          res_d = {adder_sum, res_q[WORD_BITS-1:1]};
        end else begin
          res_d = res_q;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        busy_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign acc_word = acc_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
